// File: rtl/weight_bank_scheduler_pkg.sv
// rtl/weight_bank_scheduler_pkg.sv - shared widths, bank base address and FSM encoding
// for the weight bank scheduler.
package weight_bank_scheduler_pkg;

    localparam int WEIGHT_WRITE_ADDR_WIDTH = 10;
    localparam int WEIGHT_RAM_HALF         = 512;
    localparam int KERNEL_NUM_WIDTH        = 10;
    localparam int WEIGHT_READ_ADDR_WIDTH  = 10;
    localparam int PARA_KERNEL             = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/weight_bank_scheduler_kernel_group_counter.sv
// rtl/weight_bank_scheduler_kernel_group_counter.sv - per-layer group count, load/release
// counters and the layer-complete flag.
module kernel_group_counter #(
    parameter int CNT_WIDTH  = 10,
    parameter int GROUP_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 layer_start,
    input  logic [CNT_WIDTH-1:0] kernel_num,
    input  logic                 load_inc,
    input  logic                 rel_inc,
    output logic [CNT_WIDTH-1:0] start_groups,
    output logic [CNT_WIDTH-1:0] load_cnt,
    output logic                 loads_pending,
    output logic                 layer_done
);

    logic [CNT_WIDTH-1:0] groups;
    logic [CNT_WIDTH-1:0] rel_cnt;
    logic [CNT_WIDTH-1:0] rel_cnt_n;
    logic [CNT_WIDTH:0]   padded;
    logic                 started;

    // One extra bit keeps the ceiling rounding from wrapping near the top of the range.
    always_comb begin
        padded        = {1'b0, kernel_num} + (CNT_WIDTH+1)'(GROUP_SIZE - 1);
        start_groups  = CNT_WIDTH'(padded / (CNT_WIDTH+1)'(GROUP_SIZE));
        rel_cnt_n     = rel_cnt + CNT_WIDTH'(rel_inc);
        loads_pending = (load_cnt < groups);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            groups     <= '0;
            load_cnt   <= '0;
            rel_cnt    <= '0;
            started    <= 1'b0;
            layer_done <= 1'b0;
        end else if (layer_start) begin
            groups     <= start_groups;
            load_cnt   <= '0;
            rel_cnt    <= '0;
            started    <= 1'b1;
            layer_done <= (start_groups == '0);
        end else begin
            if (load_inc) begin
                load_cnt <= load_cnt + 1'b1;
            end
            rel_cnt    <= rel_cnt_n;
            layer_done <= started && (rel_cnt_n == groups);
        end
    end

endmodule

// File: rtl/weight_bank_scheduler.sv
// rtl/weight_bank_scheduler.sv - ping-pong weight RAM bank loader: requests one kernel
// group per bank from the transfer unit while compute drains the other bank.
module weight_bank_scheduler
    import weight_bank_scheduler_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               layer_start,
    input  logic [KERNEL_NUM_WIDTH-1:0]        kernel_num,
    input  logic [WEIGHT_READ_ADDR_WIDTH-1:0]  group_words,
    input  logic                               weight_data_done,
    input  logic                               bank_release,
    output logic                               update_weight_ram,
    output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] update_weight_ram_addr,
    output logic [WEIGHT_READ_ADDR_WIDTH-1:0]  write_weight_num,
    output logic                               read_bank_ready,
    output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] read_base_addr,
    output logic [KERNEL_NUM_WIDTH-1:0]        read_group_idx,
    output logic                               layer_weights_done,
    output logic                               busy
);

    localparam logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] BANK1_ADDR =
        WEIGHT_WRITE_ADDR_WIDTH'(WEIGHT_RAM_HALF);

    sched_state_t                state;
    logic [1:0]                  valid;
    logic [1:0]                  valid_n;
    logic                        wr_bank;
    logic                        wr_bank_n;
    logic                        rd_bank;
    logic                        rd_bank_n;
    logic [KERNEL_NUM_WIDTH-1:0] grp_tag [2];
    logic [KERNEL_NUM_WIDTH-1:0] grp_idx_n;
    logic                        load_done;
    logic                        release_ok;
    logic [KERNEL_NUM_WIDTH-1:0] start_groups;
    logic [KERNEL_NUM_WIDTH-1:0] load_cnt;
    logic                        loads_pending;

    assign load_done  = (state == ST_WAIT) && weight_data_done && !layer_start;
    assign release_ok = bank_release && valid[rd_bank] && !layer_start;

    kernel_group_counter #(
        .CNT_WIDTH  (KERNEL_NUM_WIDTH),
        .GROUP_SIZE (PARA_KERNEL)
    ) u_group_counter (
        .clk           (clk),
        .rst           (rst),
        .layer_start   (layer_start),
        .kernel_num    (kernel_num),
        .load_inc      (load_done),
        .rel_inc       (release_ok),
        .start_groups  (start_groups),
        .load_cnt      (load_cnt),
        .loads_pending (loads_pending),
        .layer_done    (layer_weights_done)
    );

    // A completion and a release in one cycle always touch different banks.
    always_comb begin
        valid_n   = valid;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        if (layer_start) begin
            valid_n   = 2'b00;
            wr_bank_n = 1'b0;
            rd_bank_n = 1'b0;
        end else begin
            if (load_done) begin
                valid_n[wr_bank] = 1'b1;
                wr_bank_n        = ~wr_bank;
            end
            if (release_ok) begin
                valid_n[rd_bank] = 1'b0;
                rd_bank_n        = ~rd_bank;
            end
        end
        grp_idx_n = grp_tag[rd_bank_n];
        if (load_done && (wr_bank == rd_bank_n)) begin
            grp_idx_n = load_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= ST_IDLE;
            valid                  <= 2'b00;
            wr_bank                <= 1'b0;
            rd_bank                <= 1'b0;
            grp_tag[0]             <= '0;
            grp_tag[1]             <= '0;
            update_weight_ram      <= 1'b0;
            update_weight_ram_addr <= '0;
            write_weight_num       <= '0;
            read_bank_ready        <= 1'b0;
            read_base_addr         <= '0;
            read_group_idx         <= '0;
            busy                   <= 1'b0;
        end else begin
            valid           <= valid_n;
            wr_bank         <= wr_bank_n;
            rd_bank         <= rd_bank_n;
            read_bank_ready <= valid_n[rd_bank_n];
            read_base_addr  <= rd_bank_n ? BANK1_ADDR : '0;
            read_group_idx  <= grp_idx_n;
            if (load_done) begin
                grp_tag[wr_bank] <= load_cnt;
            end

            if (layer_start) begin
                write_weight_num       <= group_words;
                update_weight_ram_addr <= '0;
                if (state == ST_REQ || state == ST_WAIT) begin
                    // An in-flight request still needs its low gap before the next one.
                    state             <= ST_GAP;
                    update_weight_ram <= 1'b0;
                    busy              <= 1'b1;
                end else if (state == ST_IDLE && start_groups != '0) begin
                    state             <= ST_REQ;
                    update_weight_ram <= 1'b1;
                    busy              <= 1'b1;
                end else begin
                    state             <= ST_IDLE;
                    update_weight_ram <= 1'b0;
                    busy              <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (loads_pending && !valid[wr_bank]) begin
                            state                  <= ST_REQ;
                            update_weight_ram      <= 1'b1;
                            update_weight_ram_addr <= wr_bank ? BANK1_ADDR : '0;
                            busy                   <= 1'b1;
                        end
                    end
                    // Done seen here is left over from the previous load; skip it.
                    ST_REQ:  state <= ST_WAIT;
                    ST_WAIT: begin
                        if (weight_data_done) begin
                            state             <= ST_GAP;
                            update_weight_ram <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_bank_scheduler.sv
// tb/tb_weight_bank_scheduler.sv - randomized layers against a transaction-level bank model
// with a transfer-unit model that holds done until the next request edge.
module tb_weight_bank_scheduler;
    import weight_bank_scheduler_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst = 1'b0;
    logic                               layer_start = 1'b0;
    logic [KERNEL_NUM_WIDTH-1:0]        kernel_num = '0;
    logic [WEIGHT_READ_ADDR_WIDTH-1:0]  group_words = '0;
    logic                               weight_data_done = 1'b0;
    logic                               bank_release = 1'b0;
    logic                               update_weight_ram;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] update_weight_ram_addr;
    logic [WEIGHT_READ_ADDR_WIDTH-1:0]  write_weight_num;
    logic                               read_bank_ready;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] read_base_addr;
    logic [KERNEL_NUM_WIDTH-1:0]        read_group_idx;
    logic                               layer_weights_done;
    logic                               busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   tx_lat = 3;
    int   tx_cnt = 0;
    logic tx_prev = 1'b0;
    int   cur_groups = 0;
    int   cur_gw = 0;
    int   m_req_k = 0;
    int   rel_done_cnt = 0;
    logic m_prev_upd = 1'b0;
    logic m_prev_rise = 1'b0;
    logic m_prev_done = 1'b0;
    logic m_rise;
    int   low_cnt = 100;

    weight_bank_scheduler dut (
        .clk                    (clk),
        .rst                    (rst),
        .layer_start            (layer_start),
        .kernel_num             (kernel_num),
        .group_words            (group_words),
        .weight_data_done       (weight_data_done),
        .bank_release           (bank_release),
        .update_weight_ram      (update_weight_ram),
        .update_weight_ram_addr (update_weight_ram_addr),
        .write_weight_num       (write_weight_num),
        .read_bank_ready        (read_bank_ready),
        .read_base_addr         (read_base_addr),
        .read_group_idx         (read_group_idx),
        .layer_weights_done     (layer_weights_done),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int base_of(input int grp);
        return (grp % 2 == 1) ? WEIGHT_RAM_HALF : 0;
    endfunction

    // Transfer unit: clears done on the request rising edge, raises it tx_lat cycles later,
    // then holds it until the next request edge.
    always @(posedge clk) begin
        if (!rst) begin
            weight_data_done <= 1'b0;
            tx_prev          <= 1'b0;
            tx_cnt           <= 0;
        end else begin
            tx_prev <= update_weight_ram;
            if (update_weight_ram && !tx_prev) begin
                weight_data_done <= 1'b0;
                tx_cnt           <= tx_lat;
            end else if (update_weight_ram && tx_cnt > 1) begin
                tx_cnt <= tx_cnt - 1;
            end else if (update_weight_ram && tx_cnt == 1) begin
                weight_data_done <= 1'b1;
                tx_cnt           <= 0;
            end
        end
    end

    // Request monitor: address alternation, word count, bank availability and gap rules.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_prev_upd  = 1'b0;
            m_prev_rise = 1'b0;
            m_prev_done = 1'b0;
            low_cnt     = 100;
        end else begin
            m_rise = update_weight_ram && !m_prev_upd;
            if (m_prev_rise) check("req_held", int'(update_weight_ram), 1);
            if (m_prev_upd && m_prev_done && !m_prev_rise) check("req_drop", int'(update_weight_ram), 0);
            if (m_rise) begin
                check("req_addr", int'(update_weight_ram_addr), base_of(m_req_k));
                check("req_words", int'(write_weight_num), cur_gw);
                check("req_in_range", int'(m_req_k < cur_groups), 1);
                check("req_bank_free", int'(m_req_k - rel_done_cnt < 2), 1);
                check("req_gap", int'(low_cnt >= 2), 1);
                m_req_k++;
            end
            low_cnt     = update_weight_ram ? 0 : ((low_cnt < 100) ? low_cnt + 1 : low_cnt);
            m_prev_upd  = update_weight_ram;
            m_prev_rise = m_rise;
            m_prev_done = weight_data_done;
        end
    end

    task automatic run_releases(input int groups);
        int rel = 0;
        int cyc = 0;
        while (rel < groups && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(0, 2) == 0) begin
                if (read_bank_ready) begin
                    check("rd_idx", int'(read_group_idx), rel);
                    check("rd_base", int'(read_base_addr), base_of(rel));
                    check("done_early", int'(layer_weights_done), 0);
                    bank_release = 1'b1;
                    rel_done_cnt = rel + 1;
                    @(negedge clk);
                    bank_release = 1'b0;
                    rel++;
                    check("rel_base", int'(read_base_addr), base_of(rel));
                    if (rel == groups) begin
                        check("layer_done", int'(layer_weights_done), 1);
                        check("layer_reqs", m_req_k, groups);
                        check("final_ready", int'(read_bank_ready), 0);
                        check("final_busy", int'(busy), 0);
                    end
                end else begin
                    bank_release = 1'b1;
                    @(negedge clk);
                    bank_release = 1'b0;
                    check("ign_base", int'(read_base_addr), base_of(rel));
                end
            end
        end
        if (rel < groups) check("rel_timeout", rel, groups);
    endtask

    task automatic run_layer(input int kn, input int gw, input int lat, input int hold);
        int groups;
        groups       = (kn + PARA_KERNEL - 1) / PARA_KERNEL;
        kernel_num   = KERNEL_NUM_WIDTH'(kn);
        group_words  = WEIGHT_READ_ADDR_WIDTH'(gw);
        tx_lat       = lat;
        cur_groups   = groups;
        cur_gw       = gw;
        m_req_k      = 0;
        rel_done_cnt = 0;
        layer_start  = 1'b1;
        @(negedge clk);
        layer_start  = 1'b0;
        check("start_req", int'(update_weight_ram), (groups > 0) ? 1 : 0);
        check("start_done", int'(layer_weights_done), (groups == 0) ? 1 : 0);
        check("start_ready", int'(read_bank_ready), 0);
        if (groups == 0) begin
            repeat (20) @(negedge clk);
            check("zero_reqs", m_req_k, 0);
            check("zero_busy", int'(busy), 0);
            check("zero_done", int'(layer_weights_done), 1);
        end else begin
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check("hold_reqs", m_req_k, (groups < 2) ? groups : 2);
                check("hold_upd", int'(update_weight_ram), 0);
                check("hold_ready", int'(read_bank_ready), 1);
                check("hold_idx", int'(read_group_idx), 0);
                check("hold_busy", int'(busy), 0);
            end
            run_releases(groups);
        end
    endtask

    initial begin
        int w;
        #12;
        check("rst_upd", int'(update_weight_ram), 0);
        check("rst_addr", int'(update_weight_ram_addr), 0);
        check("rst_num", int'(write_weight_num), 0);
        check("rst_ready", int'(read_bank_ready), 0);
        check("rst_base", int'(read_base_addr), 0);
        check("rst_idx", int'(read_group_idx), 0);
        check("rst_done", int'(layer_weights_done), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_layer(20, 36, 3, 0);
        run_layer(0, 99, 2, 0);
        run_layer(32, 50, 2, 60);

        // Restart while a request is waiting for done.
        kernel_num   = KERNEL_NUM_WIDTH'(24);
        group_words  = WEIGHT_READ_ADDR_WIDTH'(12);
        tx_lat       = 30;
        cur_groups   = 3;
        cur_gw       = 12;
        m_req_k      = 0;
        rel_done_cnt = 0;
        layer_start  = 1'b1;
        @(negedge clk);
        layer_start  = 1'b0;
        check("ls_first_req", int'(update_weight_ram), 1);
        repeat (2) @(negedge clk);
        check("ls_wait_upd", int'(update_weight_ram), 1);
        layer_start = 1'b1;
        m_req_k     = 0;
        tx_lat      = 3;
        @(negedge clk);
        layer_start = 1'b0;
        check("ls_drop", int'(update_weight_ram), 0);
        check("ls_ready", int'(read_bank_ready), 0);
        check("ls_busy", int'(busy), 1);
        w = 0;
        while (!update_weight_ram && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("ls_rereq", int'(update_weight_ram), 1);
        check("ls_addr", int'(update_weight_ram_addr), 0);
        run_releases(3);

        for (int i = 0; i < 6; i++) begin
            run_layer($urandom_range(0, 45), $urandom_range(1, 1023), $urandom_range(1, 6), 0);
        end

        // Asynchronous reset while the second request is in WAIT.
        kernel_num   = KERNEL_NUM_WIDTH'(16);
        group_words  = WEIGHT_READ_ADDR_WIDTH'(77);
        tx_lat       = 4;
        cur_groups   = 2;
        cur_gw       = 77;
        m_req_k      = 0;
        rel_done_cnt = 0;
        layer_start  = 1'b1;
        @(negedge clk);
        layer_start  = 1'b0;
        w = 0;
        while (m_req_k < 2 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_wait", m_req_k, 2);
        @(negedge clk);
        check("pre_rst_upd", int'(update_weight_ram), 1);
        check("pre_rst_addr", int'(update_weight_ram_addr), WEIGHT_RAM_HALF);
        #2;
        rst = 1'b0;
        #1;
        check("arst_upd", int'(update_weight_ram), 0);
        check("arst_addr", int'(update_weight_ram_addr), 0);
        check("arst_num", int'(write_weight_num), 0);
        check("arst_ready", int'(read_bank_ready), 0);
        check("arst_base", int'(read_base_addr), 0);
        check("arst_idx", int'(read_group_idx), 0);
        check("arst_done", int'(layer_weights_done), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
